// File: rtl/mem_slave_responder.sv
// mem_slave_responder
//   Slave-side endpoint of a crossbar slave port. A one-cycle req carries a
//   read or write to a word-addressed RAM. An ack pulse follows after ACK_LAT
//   extra cycles. For reads, a resp pulse with rdata follows the ack after
//   RESP_LAT further cycles. While stall is high the latency countdown is
//   frozen, so ack and resp are held back.
//
// Parameters
//   ADDR_W     width of addr (word address, slave-select bits already stripped)
//   DEPTH_LOG2 RAM depth is 2**DEPTH_LOG2 words; only addr[DEPTH_LOG2-1:0] is used
//   ACK_LAT    extra cycles from req sample to ack (0..15)
//   RESP_LAT   extra cycles from ack to resp for reads (0..15)
//
// Ports
//   clk, rst   clock, synchronous active-high reset
//   req        one-cycle request strobe; cmd/addr/wdata valid with it
//   cmd        0 = read, 1 = write
//   addr       word address
//   wdata      write data
//   stall      freezes latency counting in the wait states
//   ack        one-cycle acknowledge
//   resp       one-cycle read response strobe
//   rdata      read data, valid with resp, held until the next resp
//   busy       a transaction is in progress
//   proto_err  sticky flag: req seen while busy (cleared only by rst)
module mem_slave_responder #(
  parameter int ADDR_W     = 30,
  parameter int DEPTH_LOG2 = 8,
  parameter int ACK_LAT    = 0,
  parameter int RESP_LAT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              stall,
  output logic              ack,
  output logic              resp,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              proto_err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] ACK_CNT  = 4'(ACK_LAT);
  localparam logic [3:0] RESP_CNT = 4'(RESP_LAT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACK_WAIT  = 2'd1,
    ST_RESP_WAIT = 2'd2
  } state_t;

  state_t                  state_r;
  logic [3:0]              cnt_r;
  logic                    cmd_r;
  logic [DEPTH_LOG2-1:0]   idx_r;
  logic [31:0]             wdata_r;
  logic [31:0]             mem_r [DEPTH];

  logic                    ack_fire_s;
  logic                    resp_fire_s;
  logic                    ram_we_s;
  logic                    addr_unused_s;

  // Upper address bits alias onto the RAM; they are intentionally dropped.
  assign addr_unused_s = ^addr[ADDR_W-1:DEPTH_LOG2];

  // Decode the edges on which ack/resp fire and the RAM is written.
  always_comb begin
    ack_fire_s  = 1'b0;
    resp_fire_s = 1'b0;
    ram_we_s    = 1'b0;
    if ((state_r == ST_ACK_WAIT) && !stall && (cnt_r == 4'd0)) begin
      ack_fire_s = 1'b1;
    end else begin
      ack_fire_s = 1'b0;
    end
    if ((state_r == ST_RESP_WAIT) && !stall && (cnt_r == 4'd0)) begin
      resp_fire_s = 1'b1;
    end else begin
      resp_fire_s = 1'b0;
    end
    // A write lands on the same edge that raises ack; reset aborts it.
    if (ack_fire_s && cmd_r && !rst) begin
      ram_we_s = 1'b1;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // Backing RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      cmd_r     <= 1'b0;
      idx_r     <= '0;
      wdata_r   <= 32'd0;
      ack       <= 1'b0;
      resp      <= 1'b0;
      rdata     <= 32'd0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      // ack and resp are single-cycle pulses.
      ack  <= 1'b0;
      resp <= 1'b0;
      if (req && (state_r != ST_IDLE)) begin
        proto_err <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            cmd_r   <= cmd;
            idx_r   <= addr[DEPTH_LOG2-1:0];
            wdata_r <= wdata;
            cnt_r   <= ACK_CNT;
            busy    <= 1'b1;
            state_r <= ST_ACK_WAIT;
          end
        end
        ST_ACK_WAIT: begin
          if (stall) begin
            state_r <= ST_ACK_WAIT;
          end else if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            ack <= 1'b1;
            if (cmd_r) begin
              busy    <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              cnt_r   <= RESP_CNT;
              state_r <= ST_RESP_WAIT;
            end
          end
        end
        ST_RESP_WAIT: begin
          if (stall) begin
            state_r <= ST_RESP_WAIT;
          end else if (resp_fire_s) begin
            resp    <= 1'b1;
            rdata   <= mem_r[idx_r];
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_slave_responder.sv
// tb_mem_slave_responder
//   Drives two responders (ACK_LAT=0/RESP_LAT=0 and ACK_LAT=2/RESP_LAT=3)
//   with directed and random transactions. A transaction-level model predicts,
//   for each clock edge, whether ack/resp fire. It does this by counting
//   non-stalled edges after the request. The model also tracks RAM contents,
//   held rdata and the sticky proto_err flag.
module tb_mem_slave_responder;

  localparam int AW = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          rst_v   = 2'b11;
  logic [1:0]          req_v   = 2'b00;
  logic [1:0]          cmd_v   = 2'b00;
  logic [1:0]          stall_v = 2'b00;
  logic [1:0][AW-1:0]  addr_v  = '0;
  logic [1:0][31:0]    wdata_v = '0;
  logic [1:0]          ack_v, resp_v, busy_v, perr_v;
  logic [1:0][31:0]    rdata_v;

  mem_slave_responder #(.ADDR_W(AW), .DEPTH_LOG2(8), .ACK_LAT(0), .RESP_LAT(0)) dut0 (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .cmd(cmd_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .stall(stall_v[0]), .ack(ack_v[0]), .resp(resp_v[0]),
    .rdata(rdata_v[0]), .busy(busy_v[0]), .proto_err(perr_v[0])
  );

  mem_slave_responder #(.ADDR_W(AW), .DEPTH_LOG2(8), .ACK_LAT(2), .RESP_LAT(3)) dut1 (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .cmd(cmd_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .stall(stall_v[1]), .ack(ack_v[1]), .resp(resp_v[1]),
    .rdata(rdata_v[1]), .busy(busy_v[1]), .proto_err(perr_v[1])
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mem_m   [2][256];
  logic [31:0] rdata_m [2];
  logic [1:0]  perr_m  = 2'b00;
  int          ae, re;

  function automatic int lat_ack(input int sel);
    return (sel == 1) ? 2 : 0;
  endfunction

  function automatic int lat_resp(input int sel);
    return (sel == 1) ? 3 : 0;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one transaction on responder sel; must be entered just after a negedge.
  // smode: 0 no stall, 1 random stall, 2 stall on edges 5 and 6 after the req.
  task automatic do_txn(input int sel, input bit c, input logic [AW-1:0] a,
                        input logic [31:0] wd, input int smode, input bit inj,
                        output int ack_e, output int resp_e);
    int       j, na, nr, ph;
    bit       s, e_ack, e_resp, e_busy;
    logic [7:0] idx;
    idx = a[7:0];
    ack_e = -1; resp_e = -1; na = 0; nr = 0; ph = 1; j = 0;
    req_v[sel] = 1'b1; cmd_v[sel] = c; addr_v[sel] = a; wdata_v[sel] = wd;
    stall_v[sel] = 1'($urandom_range(0, 1));
    e_ack = 1'b0; e_resp = 1'b0; e_busy = 1'b1;
    forever begin
      @(negedge clk);
      check_val("ack",   32'(ack_v[sel]),  32'(e_ack));
      check_val("resp",  32'(resp_v[sel]), 32'(e_resp));
      check_val("busy",  32'(busy_v[sel]), 32'(e_busy));
      check_val("perr",  32'(perr_v[sel]), 32'(perr_m[sel]));
      check_val("rdata", rdata_v[sel],     rdata_m[sel]);
      if (ack_v[sel])  ack_e  = j;
      if (resp_v[sel]) resp_e = j;
      if (ph == 0) break;
      j++;
      if (j > 80) begin
        check_val("txn_timeout", 32'(j), 32'd80);
        break;
      end
      case (smode)
        0:       s = 1'b0;
        1:       s = ($urandom_range(0, 99) < 30);
        2:       s = (j == 5) || (j == 6);
        default: s = 1'b0;
      endcase
      stall_v[sel] = s;
      req_v[sel]   = inj && (j == 1);
      cmd_v[sel]   = 1'($urandom);
      addr_v[sel]  = AW'($urandom);
      wdata_v[sel] = $urandom;
      if (inj && (j == 1)) perr_m[sel] = 1'b1;
      e_ack = 1'b0; e_resp = 1'b0;
      if ((ph == 1) && !s) begin
        na++;
        if (na == lat_ack(sel) + 1) begin
          e_ack = 1'b1;
          if (c) begin
            mem_m[sel][idx] = wd;
            ph = 0;
          end else begin
            ph = 2;
          end
        end
      end else if ((ph == 2) && !s) begin
        nr++;
        if (nr == lat_resp(sel) + 1) begin
          e_resp = 1'b1;
          rdata_m[sel] = mem_m[sel][idx];
          ph = 0;
        end
      end
      e_busy = (ph != 0);
    end
    req_v[sel] = 1'b0;
    stall_v[sel] = 1'b0;
  endtask

  task automatic do_reset(input int sel);
    rst_v[sel] = 1'b1; req_v[sel] = 1'b0; stall_v[sel] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_ack",   32'(ack_v[sel]),  32'd0);
    check_val("rst_resp",  32'(resp_v[sel]), 32'd0);
    check_val("rst_busy",  32'(busy_v[sel]), 32'd0);
    check_val("rst_perr",  32'(perr_v[sel]), 32'd0);
    check_val("rst_rdata", rdata_v[sel],     32'd0);
    rst_v[sel] = 1'b0;
    rdata_m[sel] = 32'd0;
    perr_m[sel] = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a;
    rdata_m[0] = 32'd0; rdata_m[1] = 32'd0;
    do_reset(0);
    do_reset(1);

    // Give words 0..15 known contents, through aliased addresses.
    for (int sel = 0; sel < 2; sel++) begin
      for (int i = 0; i < 16; i++) begin
        a = AW'($urandom);
        a[7:0] = 8'(i);
        do_txn(sel, 1'b1, a, $urandom, 0, 1'b0, ae, re);
      end
    end

    // Write then read with zero latency.
    do_txn(0, 1'b1, 30'd5, 32'hDEADBEEF, 0, 1'b0, ae, re);
    check_val("w0_ack_edge",  32'(ae), 32'd1);
    check_val("w0_no_resp",   32'(re), 32'hFFFFFFFF);
    do_txn(0, 1'b0, 30'd5, 32'd0, 0, 1'b0, ae, re);
    check_val("r0_ack_edge",  32'(ae), 32'd1);
    check_val("r0_resp_edge", 32'(re), 32'd2);
    check_val("r0_deadbeef",  rdata_v[0], 32'hDEADBEEF);

    // Latency 2/3, without and with a two-cycle stall in the response wait.
    do_txn(1, 1'b0, 30'd5, 32'd0, 0, 1'b0, ae, re);
    check_val("r1_ack_edge",  32'(ae), 32'd3);
    check_val("r1_resp_edge", 32'(re), 32'd7);
    do_txn(1, 1'b0, 30'd9, 32'd0, 2, 1'b0, ae, re);
    check_val("r1s_ack_edge",  32'(ae), 32'd3);
    check_val("r1s_resp_edge", 32'(re), 32'd9);

    // Aliasing: 0x103 and 0x003 share a word.
    do_txn(0, 1'b1, 30'h103, 32'h1, 1, 1'b0, ae, re);
    do_txn(0, 1'b0, 30'h003, 32'd0, 1, 1'b0, ae, re);
    check_val("alias_rdata", rdata_v[0], 32'h1);

    // Request while busy is ignored and flagged.
    do_txn(1, 1'b0, 30'd5, 32'd0, 0, 1'b1, ae, re);
    check_val("perr_ack_edge", 32'(ae), 32'd3);
    check_val("perr_sticky",   32'(perr_v[1]), 32'd1);

    // Reset while waiting for the response.
    req_v[1] = 1'b1; cmd_v[1] = 1'b0; addr_v[1] = 30'd5;
    @(negedge clk);
    req_v[1] = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rw_busy", 32'(busy_v[1]), 32'd1);
    rst_v[1] = 1'b1;
    @(negedge clk);
    rst_v[1] = 1'b0;
    rdata_m[1] = 32'd0;
    perr_m[1] = 1'b0;
    check_val("rw_rdata", rdata_v[1],      32'd0);
    check_val("rw_perr",  32'(perr_v[1]),  32'd0);
    for (int k = 0; k < 6; k++) begin
      check_val("rw_ack",  32'(ack_v[1]),  32'd0);
      check_val("rw_resp", 32'(resp_v[1]), 32'd0);
      check_val("rw_idle", 32'(busy_v[1]), 32'd0);
      @(negedge clk);
    end
    do_txn(1, 1'b0, 30'd5, 32'd0, 0, 1'b0, ae, re);
    check_val("rw_next_resp", 32'(re), 32'd7);

    // Random traffic on words 0..15 with random upper address bits.
    for (int t = 0; t < 200; t++) begin
      int sel;
      sel = $urandom_range(0, 1);
      a = AW'($urandom);
      a[7:4] = 4'd0;
      do_txn(sel, 1'($urandom), a, $urandom, $urandom_range(0, 2),
             ($urandom_range(0, 19) == 0), ae, re);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
